// File: rtl/tcs3200_scan_ctrl.sv
// TCS3200 colour-sensor scan sequencer: settles and gates each filter (R, G, B, Clear) in turn,
// then publishes all four counts at once. Define TCS3200_AUTO_RANGE_EN for automatic S0/S1 ranging.
`timescale 1ns/1ps
module tcs3200_scan_ctrl #(
  parameter int unsigned GATE_CYCLES   = 5000000,
  parameter int unsigned SETTLE_CYCLES = 50000,
  parameter int unsigned CNT_W         = 21,
  parameter logic [1:0]  SCALE_DEF     = 2'b10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             sensor_out,
  output logic [1:0]       s0_s1,
  output logic [1:0]       s2_s3,
  output logic             led_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic [CNT_W-1:0] clear_cnt,
  output logic             sat,
  output logic             no_signal
);

  localparam int unsigned MaxWin = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TmrW   = (MaxWin < 2) ? 1 : $clog2(MaxWin + 1);
  localparam logic [TmrW-1:0]  SettleLast = TmrW'(SETTLE_CYCLES - 1);
  localparam logic [TmrW-1:0]  GateLast   = TmrW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax     = '1;

  localparam logic [1:0] ChR = 2'd0;
  localparam logic [1:0] ChG = 2'd1;
  localparam logic [1:0] ChB = 2'd2;
  localparam logic [1:0] ChC = 2'd3;

  typedef enum logic [1:0] {StIdle, StSettle, StGate, StStore} state_e;

  // Sensor filter select encoding is not in channel order.
  function automatic logic [1:0] filter_code(input logic [1:0] ch);
    case (ch)
      ChR:     filter_code = 2'b00;
      ChG:     filter_code = 2'b11;
      ChB:     filter_code = 2'b01;
      default: filter_code = 2'b10;
    endcase
  endfunction

  state_e           state_q;
  logic [1:0]       ch_q;
  logic [TmrW-1:0]  tmr_q;
  logic [CNT_W-1:0] work_cnt_q;
  logic [3:0]       sat_ch_q;
  logic [CNT_W-1:0] shadow_q [4];
  logic [1:0]       sync_q;
  logic             prev_q;

  logic             rise;
  logic [CNT_W-1:0] cnt_next;
  logic             sat_hit;
  logic             any_sat;
  logic             rescan;

  assign rise    = sync_q[1] & ~prev_q;
  assign any_sat = |sat_ch_q;

  always_comb begin
    cnt_next = work_cnt_q;
    sat_hit  = 1'b0;
    if (rise) begin
      if (work_cnt_q == CntMax) begin
        sat_hit = 1'b1;
      end else begin
        cnt_next = work_cnt_q + 1'b1;
      end
    end
  end

`ifdef TCS3200_AUTO_RANGE_EN
  localparam int unsigned      LowShift  = (CNT_W > 6) ? CNT_W - 6 : 0;
  localparam logic [CNT_W-1:0] LowThresh = CNT_W'(1) << LowShift;

  assign rescan = any_sat && (s0_s1 == 2'b11 || s0_s1 == 2'b10);
`else
  assign rescan = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ch_q       <= ChR;
      tmr_q      <= '0;
      work_cnt_q <= '0;
      sat_ch_q   <= '0;
      for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
      sync_q     <= '0;
      prev_q     <= 1'b0;
      s0_s1      <= SCALE_DEF;
      s2_s3      <= 2'b00;
      led_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      red_cnt    <= '0;
      green_cnt  <= '0;
      blue_cnt   <= '0;
      clear_cnt  <= '0;
      sat        <= 1'b0;
      no_signal  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sensor_out};
      prev_q <= sync_q[1];
      done   <= 1'b0;

      case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StSettle;
            ch_q     <= ChR;
            tmr_q    <= '0;
            sat_ch_q <= '0;
            s2_s3    <= filter_code(ChR);
            led_en   <= 1'b1;
            busy     <= 1'b1;
          end
        end

        StSettle: begin
          if (tmr_q == SettleLast) begin
            tmr_q      <= '0;
            work_cnt_q <= '0;
            state_q    <= StGate;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end

        StGate: begin
          work_cnt_q <= cnt_next;
          if (sat_hit) sat_ch_q[ch_q] <= 1'b1;
          if (tmr_q == GateLast) begin
            tmr_q          <= '0;
            shadow_q[ch_q] <= cnt_next;
            if (ch_q != ChC) begin
              ch_q    <= ch_q + 2'd1;
              s2_s3   <= filter_code(ch_q + 2'd1);
              state_q <= StSettle;
            end else begin
              state_q <= StStore;
            end
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end

        StStore: begin
          tmr_q    <= '0;
          ch_q     <= ChR;
          s2_s3    <= filter_code(ChR);
          sat_ch_q <= '0;
          if (rescan) begin
`ifdef TCS3200_AUTO_RANGE_EN
            // Saturated on a range that can still drop: discard this scan and retry lower.
            s0_s1   <= s0_s1 - 2'd1;
`endif
            state_q <= StSettle;
          end else begin
            red_cnt   <= shadow_q[ChR];
            green_cnt <= shadow_q[ChG];
            blue_cnt  <= shadow_q[ChB];
            clear_cnt <= shadow_q[ChC];
            sat       <= any_sat;
            no_signal <= (shadow_q[ChC] == '0);
            done      <= 1'b1;
`ifdef TCS3200_AUTO_RANGE_EN
            if (shadow_q[ChC] < LowThresh && (s0_s1 == 2'b01 || s0_s1 == 2'b10)) begin
              s0_s1 <= s0_s1 + 2'd1;
            end
`endif
            if (continuous) begin
              state_q <= StSettle;
            end else begin
              state_q <= StIdle;
              led_en  <= 1'b0;
              busy    <= 1'b0;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tcs3200_scan_ctrl.sv
// Directed bench for tcs3200_scan_ctrl: one 21-bit instance with a filter-keyed sensor model
// and one 4-bit instance with a fast sensor for saturation and ranging.
`timescale 1ns/1ps
module tb_tcs3200_scan_ctrl;

  localparam int unsigned G   = 100;
  localparam int unsigned S   = 10;
  localparam int          Lat = 4 * (S + G) + 1;
`ifdef TCS3200_AUTO_RANGE_EN
  localparam int          SatLat   = 2 * Lat;
  localparam logic [1:0]  SatScale = 2'b01;
`else
  localparam int          SatLat   = Lat;
  localparam logic [1:0]  SatScale = 2'b10;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start_a = 1'b0, cont_a = 1'b0, sens_a = 1'b0;
  logic start_b = 1'b0, cont_b = 1'b0, sens_b = 1'b0;
  logic sens_en = 1'b1;

  logic [1:0]  s01_a, s23_a, s01_b, s23_b;
  logic        led_a, busy_a, done_a, sat_a, nosig_a;
  logic        led_b, busy_b, done_b, sat_b, nosig_b;
  logic [20:0] r_a, g_a, b_a, c_a;
  logic [3:0]  r_b, g_b, b_b, c_b;

  int total = 0;
  int bad   = 0;
  int k     = 0;
  int per;

  tcs3200_scan_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(21), .SCALE_DEF(2'b10)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .continuous(cont_a), .sensor_out(sens_a),
    .s0_s1(s01_a), .s2_s3(s23_a), .led_en(led_a), .busy(busy_a), .done(done_a),
    .red_cnt(r_a), .green_cnt(g_a), .blue_cnt(b_a), .clear_cnt(c_a),
    .sat(sat_a), .no_signal(nosig_a)
  );

  tcs3200_scan_ctrl #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(4), .SCALE_DEF(2'b10)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .continuous(cont_b), .sensor_out(sens_b),
    .s0_s1(s01_b), .s2_s3(s23_b), .led_en(led_b), .busy(busy_b), .done(done_b),
    .red_cnt(r_b), .green_cnt(g_b), .blue_cnt(b_b), .clear_cnt(c_b),
    .sat(sat_b), .no_signal(nosig_b)
  );

  always #5 clk = ~clk;

  // Sensor periods: red 4, green 5, blue 10, clear 2 cycles.
  always @(negedge clk) begin
    k++;
    case (s23_a)
      2'b00:   per = 4;
      2'b11:   per = 5;
      2'b01:   per = 10;
      default: per = 2;
    endcase
    sens_a = sens_en && ((k % per) < (per / 2));
    sens_b = ((k % 2) == 0);
  end

  task automatic kick_a();
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
  endtask

  task automatic kick_b();
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
  endtask

  task automatic wait_done_a(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (done_a !== 1'b1 && n < 3000);
  endtask

  task automatic wait_done_b(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (done_b !== 1'b1 && n < 3000);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (r_a !== 21'd0 || c_a !== 21'd0) begin bad++;
      $display("FAIL reset_cnt: got r=%0d c=%0d want 0", r_a, c_a); end
    total++; if ({busy_a, led_a, done_a} !== 3'b000) begin bad++;
      $display("FAIL reset_ctl: got busy/led/done=%b want 000", {busy_a, led_a, done_a}); end
    total++; if ({sat_a, nosig_a} !== 2'b00) begin bad++;
      $display("FAIL reset_flags: got %b want 00", {sat_a, nosig_a}); end
    total++; if (s01_a !== 2'b10 || s23_a !== 2'b00) begin bad++;
      $display("FAIL reset_sel: got s01=%b s23=%b want 10/00", s01_a, s23_a); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_single();
    int n;
    kick_a();
    total++; if ({busy_a, led_a} !== 2'b11 || s23_a !== 2'b00) begin bad++;
      $display("FAIL single_begin: got busy/led=%b s23=%b want 11/00", {busy_a, led_a}, s23_a); end
    wait_done_a(n);
    total++; if (n != Lat) begin bad++;
      $display("FAIL single_latency: got %0d want %0d", n, Lat); end
    total++; if (r_a !== 21'd25 || g_a !== 21'd20) begin bad++;
      $display("FAIL single_rg: got %0d/%0d want 25/20", r_a, g_a); end
    total++; if (b_a !== 21'd10 || c_a !== 21'd50) begin bad++;
      $display("FAIL single_bc: got %0d/%0d want 10/50", b_a, c_a); end
    total++; if ({sat_a, nosig_a} !== 2'b00) begin bad++;
      $display("FAIL single_flags: got %b want 00", {sat_a, nosig_a}); end
    total++; if ({busy_a, led_a} !== 2'b00 || s23_a !== 2'b00) begin bad++;
      $display("FAIL single_end: got busy/led=%b s23=%b want 00/00", {busy_a, led_a}, s23_a); end
    @(posedge clk); #1;
    total++; if (done_a !== 1'b0) begin bad++;
      $display("FAIL single_pulse: got done=%b want 0", done_a); end
  endtask

  task automatic test_reset_mid_gate();
    bit seen = 1'b0;
    kick_a();
    repeat (50) @(posedge clk);
    #3; rst = 1'b0;
    #1;
    total++; if (r_a !== 21'd0 || c_a !== 21'd0) begin bad++;
      $display("FAIL midrst_cnt: got r=%0d c=%0d want 0", r_a, c_a); end
    total++; if ({busy_a, led_a, done_a, sat_a, nosig_a} !== 5'b0) begin bad++;
      $display("FAIL midrst_ctl: got %b want 00000", {busy_a, led_a, done_a, sat_a, nosig_a}); end
    total++; if (s01_a !== 2'b10 || s23_a !== 2'b00) begin bad++;
      $display("FAIL midrst_sel: got s01=%b s23=%b want 10/00", s01_a, s23_a); end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (done_a === 1'b1 || busy_a === 1'b1) seen = 1'b1;
    end
    total++; if (seen) begin bad++;
      $display("FAIL midrst_quiet: got activity=1 want 0"); end
  endtask

  task automatic test_saturation();
    int n;
    kick_b();
    wait_done_b(n);
    total++; if (n != SatLat) begin bad++;
      $display("FAIL sat_latency: got %0d want %0d", n, SatLat); end
    total++; if ({r_b, g_b, b_b, c_b} !== 16'hffff) begin bad++;
      $display("FAIL sat_counts: got %0d/%0d/%0d/%0d want 15 each", r_b, g_b, b_b, c_b); end
    total++; if ({sat_b, nosig_b} !== 2'b10) begin bad++;
      $display("FAIL sat_flags: got %b want 10", {sat_b, nosig_b}); end
    total++; if (s01_b !== SatScale) begin bad++;
      $display("FAIL sat_scale: got %b want %b", s01_b, SatScale); end
  endtask

  task automatic test_auto_range();
    int n;
    kick_b();
    repeat (200) @(posedge clk);
    #1;
    total++; if (s01_b !== SatScale || done_b !== 1'b0) begin bad++;
      $display("FAIL range_mid: got s01=%b done=%b want %b/0", s01_b, done_b, SatScale); end
    wait_done_b(n);
    total++; if (n + 200 != Lat) begin bad++;
      $display("FAIL range_latency: got %0d want %0d", n + 200, Lat); end
    total++; if (s01_b !== SatScale || sat_b !== 1'b1) begin bad++;
      $display("FAIL range_end: got s01=%b sat=%b want %b/1", s01_b, sat_b, SatScale); end
  endtask

  task automatic test_no_signal();
    int n;
    sens_en = 1'b0;
    kick_a();
    wait_done_a(n);
    total++; if (n != Lat) begin bad++;
      $display("FAIL nosig_latency: got %0d want %0d", n, Lat); end
    total++; if (r_a !== 21'd0 || g_a !== 21'd0 || b_a !== 21'd0 || c_a !== 21'd0) begin bad++;
      $display("FAIL nosig_counts: got %0d/%0d/%0d/%0d want 0", r_a, g_a, b_a, c_a); end
    total++; if ({sat_a, nosig_a} !== 2'b01) begin bad++;
      $display("FAIL nosig_flags: got %b want 01", {sat_a, nosig_a}); end
    sens_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int dn [4];
    int nd = 0;
    cont_a = 1'b1;
    kick_a();
    for (int n = 1; n <= 1800; n++) begin
      @(posedge clk); #1;
      if (done_a === 1'b1) begin
        if (nd < 4) dn[nd] = n;
        nd++;
      end
      start_a = (n == 100 || n == 600 || n == 1100);
      if (n == 1000) cont_a = 1'b0;
    end
    start_a = 1'b0;
    total++; if (nd != 3) begin bad++;
      $display("FAIL b2b_count: got %0d want 3", nd); end
    total++; if (dn[0] != Lat || dn[1] != 2 * Lat || dn[2] != 3 * Lat) begin bad++;
      $display("FAIL b2b_times: got %0d/%0d/%0d want %0d/%0d/%0d",
               dn[0], dn[1], dn[2], Lat, 2 * Lat, 3 * Lat); end
    total++; if (busy_a !== 1'b0 || led_a !== 1'b0 || c_a !== 21'd50) begin bad++;
      $display("FAIL b2b_idle: got busy=%b led=%b c=%0d want 0/0/50", busy_a, led_a, c_a); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid_gate();
    test_saturation();
    test_auto_range();
    test_no_signal();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
